lfsr_4: RTL and testbench

LFSR_4 -- requirements
Module: lfsr_4

---
 rtl/lfsr_4_pkg.sv | 21 ++
 rtl/lfsr_4.sv | 56 +++++
 tb/tb_lfsr_4.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_4_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_4_pkg
// Shared constants for the 4-bit Fibonacci LFSR (polynomial x^4 + x^3 + 1).
//   DEFAULT_SEED : reset value used when no SEED override is given
//   TAP_HI/TAP_LO: bit positions XORed to form the feedback bit
//   SAFE_SEED    : nonzero value substituted for an all-zero seed or state
//   safe_seed()  : maps a requested seed onto a legal (nonzero) one
// -----------------------------------------------------------------------------
package lfsr_4_pkg;

  localparam logic [3:0] DEFAULT_SEED = 4'b0001;
  localparam int         TAP_HI       = 3;
  localparam int         TAP_LO       = 2;
  localparam logic [3:0] SAFE_SEED    = 4'b0001;

  // All-zero is the lock-up state of an XOR LFSR, so it is never a legal seed.
  function automatic logic [3:0] safe_seed(input logic [3:0] seed);
    return (seed == 4'b0000) ? SAFE_SEED : seed;
  endfunction

endpackage

// File: rtl/lfsr_4.sv
// -----------------------------------------------------------------------------
// lfsr_4
// 4-bit maximal-length Fibonacci LFSR, feedback x^4 + x^3 + 1, period 15.
// Each enabled clock shifts left with lfsr[3]^lfsr[2] entering at bit 0.
//
// Parameters:
//   SEED   : reset value; 4'b0000 is replaced by 4'b0001
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; loads the seed, overrides enable
//   enable : advance one step per clock when high, hold when low
//   lfsr   : current state, driven straight from the state register
//
// Interface timing: there is no handshake. lfsr is valid on every cycle after
// the first reset edge and changes only on a rising edge where reset=1 or
// enable=1.
// -----------------------------------------------------------------------------
module lfsr_4
  import lfsr_4_pkg::*;
#(
  parameter logic [3:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] lfsr
);

  localparam logic [3:0] RESET_VAL = safe_seed(SEED);

  logic [3:0] r_lfsr;
  logic       w_feedback;
  logic [3:0] w_next;

  assign w_feedback = r_lfsr[TAP_HI] ^ r_lfsr[TAP_LO];

  // An all-zero state (only possible from an unreset power-up) would shift to
  // itself forever; steer it back onto the sequence instead.
  always_comb begin
    w_next = {r_lfsr[2:0], w_feedback};
    if (r_lfsr == 4'b0000) begin
      w_next = SAFE_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= RESET_VAL;
    end else if (enable) begin
      r_lfsr <= w_next;
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: tb/tb_lfsr_4.sv
// -----------------------------------------------------------------------------
// tb_lfsr_4
// Three instances (default seed, SEED=1000, SEED=0000) share clk/reset/enable.
// The reference model walks the published 15-entry sequence table by index;
// the driver pushes the expected triple per edge into exp_q and a monitor pops
// and compares it one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_lfsr_4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] lfsr_d;
  logic [3:0] lfsr_8;
  logic [3:0] lfsr_0;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  logic [3:0] seq_tab [15];
  int  idx_d, idx_8, idx_0;
  bit  model_ok = 0;
  logic [3:0] hist [30];

  lfsr_4 dut_d (
    .clk(clk), .reset(reset), .enable(enable), .lfsr(lfsr_d)
  );

  lfsr_4 #(.SEED(4'b1000)) dut_8 (
    .clk(clk), .reset(reset), .enable(enable), .lfsr(lfsr_8)
  );

  lfsr_4 #(.SEED(4'b0000)) dut_0 (
    .clk(clk), .reset(reset), .enable(enable), .lfsr(lfsr_0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    seq_tab[0]  = 4'b0001; seq_tab[1]  = 4'b0010; seq_tab[2]  = 4'b0100;
    seq_tab[3]  = 4'b1001; seq_tab[4]  = 4'b0011; seq_tab[5]  = 4'b0110;
    seq_tab[6]  = 4'b1101; seq_tab[7]  = 4'b1010; seq_tab[8]  = 4'b0101;
    seq_tab[9]  = 4'b1011; seq_tab[10] = 4'b0111; seq_tab[11] = 4'b1111;
    seq_tab[12] = 4'b1110; seq_tab[13] = 4'b1100; seq_tab[14] = 4'b1000;
  end

  // ---------------- reference model ----------------
  function automatic int find_idx(input logic [3:0] v);
    for (int i = 0; i < 15; i++) begin
      if (seq_tab[i] == v) return i;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_d();
    return seq_tab[idx_d];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    reset  = r;
    enable = e;
    if (r) begin
      idx_d    = find_idx(4'b0001);
      idx_8    = find_idx(4'b1000);
      idx_0    = find_idx(4'b0001);
      model_ok = 1;
    end else if (e && model_ok) begin
      idx_d = (idx_d + 1) % 15;
      idx_8 = (idx_8 + 1) % 15;
      idx_0 = (idx_0 + 1) % 15;
    end
    if (model_ok) exp_q.push_back({seq_tab[idx_d], seq_tab[idx_8], seq_tab[idx_0]});
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lfsr_default", lfsr_d, e[11:8]);
        check("lfsr_seed1000", lfsr_8, e[7:4]);
        check("lfsr_seed0000", lfsr_0, e[3:0]);
        checks++;
        if (lfsr_0 === 4'b0000 || lfsr_d === 4'b0000 || lfsr_8 === 4'b0000) begin
          errors++;
          $display("FAIL zero_state: got %b/%b/%b expected nonzero", lfsr_d, lfsr_8, lfsr_0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int distinct;
    bit seen [16];

    // Reset held with enable low, then idle: all stays at the seed.
    step(1, 0); step(1, 0);
    step(0, 0); step(0, 0);

    // 16 enabled edges: full period plus wrap to 0010.
    for (int i = 0; i < 16; i++) step(0, 1);

    // Run to 1101, hold 5 edges, then resume to 1010.
    step(1, 0);
    guard = 0;
    while (exp_d() != 4'b1101 && guard < 20) begin step(0, 1); guard++; end
    for (int i = 0; i < 5; i++) step(0, 0);
    step(0, 1);

    // Run to 0111, reset with enable high, then sequence restarts.
    guard = 0;
    while (exp_d() != 4'b0111 && guard < 20) begin step(0, 1); guard++; end
    step(1, 1);
    step(0, 1); step(0, 1);

    // Period check on the zero-seed instance over 30 enabled edges.
    step(1, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 1);
      @(posedge clk);
      #2;
      hist[i] = lfsr_0;
    end
    for (int i = 0; i < 16; i++) seen[i] = 0;
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      if (!seen[hist[i]]) distinct++;
      seen[hist[i]] = 1;
    end
    checks++;
    if (distinct != 15) begin
      errors++;
      $display("FAIL period_distinct: got %0d expected 15", distinct);
    end
    for (int i = 0; i < 15; i++) check("period_repeat", hist[i + 15], hist[i]);

    // Random enable with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
    end

    // Drain with a bounded wait.
    @(negedge clk); enable = 0; reset = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
